// File: rtl/udma_filter_pkg.sv
// Shared types and constants for the uDMA filter AU run-controller.
// The accumulate modes produce a single result per frame instead of one per sample.
package udma_filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DRAIN,
        DONE
    } sched_state_e;

    localparam logic [3:0] MODE_MAC_ACC = 4'd2;
    localparam logic [3:0] MODE_SQ_ACC  = 4'd6;
    localparam logic [3:0] MODE_REG_ACC = 4'd12;

    function automatic logic is_acc_mode(input logic [3:0] mode);
        return (mode == MODE_MAC_ACC) || (mode == MODE_SQ_ACC) || (mode == MODE_REG_ACC);
    endfunction

endpackage

// File: rtl/udma_filter_job_cnt.sv
// Saturating per-job sample counter: clears on job start, counts up to limit and stops.
module udma_filter_job_cnt #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic [LEN_WIDTH-1:0] limit_i,
    output logic [LEN_WIDTH-1:0] cnt_o,
    output logic                 hit_o
);

    logic [LEN_WIDTH-1:0] r_cnt;

    assign hit_o = (r_cnt == limit_i);
    assign cnt_o = r_cnt;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && !hit_o) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/udma_filter_au_sched.sv
// Run-controller for the uDMA filter AU: flushes the AU per job, gates operand-A,
// tags sof/eof, counts delivered results and signals completion.
module udma_filter_au_sched
    import udma_filter_pkg::*;
#(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    input  logic                 cfg_start_i,
    input  logic                 cfg_abort_i,
    input  logic [3:0]           cfg_mode_i,
    input  logic                 cfg_bypass_i,
    input  logic [LEN_WIDTH-1:0] cfg_len_i,
    output logic                 au_cmd_start_o,
    input  logic                 src_valid_i,
    output logic                 src_ready_o,
    output logic                 au_opa_valid_o,
    input  logic                 au_opa_ready_i,
    output logic                 au_opa_sof_o,
    output logic                 au_opa_eof_o,
    input  logic                 au_out_valid_i,
    output logic                 au_out_ready_o,
    output logic                 sink_valid_o,
    input  logic                 sink_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LEN_WIDTH-1:0] in_cnt_o,
    output logic [LEN_WIDTH-1:0] out_cnt_o
);

    sched_state_e         r_state;
    logic                 r_cmd_start;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_exp;

    logic w_run, w_xfer, w_in_open, w_in_hit, w_out_hit;
    logic w_in_acc, w_out_acc, w_clr, w_launch;

    assign w_run     = (r_state == RUN);
    assign w_xfer    = (r_state == RUN) || (r_state == DRAIN);
    assign w_in_open = w_run && !w_in_hit;

    assign src_ready_o    = au_opa_ready_i && w_in_open;
    assign au_opa_valid_o = src_valid_i && w_in_open;
    assign au_opa_sof_o   = au_opa_valid_o && (in_cnt_o == '0);
    assign au_opa_eof_o   = au_opa_valid_o && (in_cnt_o == r_len - 1'b1);

    // Result path passes straight through; results past the expected count are dropped.
    assign au_out_ready_o = w_xfer && sink_ready_i;
    assign sink_valid_o   = w_xfer && au_out_valid_i && !w_out_hit;

    // Counters freeze on abort so the partial progress stays readable.
    assign w_in_acc  = src_valid_i && src_ready_o && !cfg_abort_i;
    assign w_out_acc = sink_valid_o && sink_ready_i && !cfg_abort_i;
    assign w_launch  = !cfg_abort_i && (r_state == IDLE) && cfg_start_i;
    assign w_clr     = w_launch && (cfg_len_i != '0);

    assign au_cmd_start_o = r_cmd_start;
    assign busy_o         = (r_state == START) || w_xfer;
    assign done_o         = (r_state == DONE);

    udma_filter_job_cnt #(.LEN_WIDTH(LEN_WIDTH)) u_in_cnt (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clr_i    (w_clr),
        .inc_i    (w_in_acc),
        .limit_i  (r_len),
        .cnt_o    (in_cnt_o),
        .hit_o    (w_in_hit)
    );

    udma_filter_job_cnt #(.LEN_WIDTH(LEN_WIDTH)) u_out_cnt (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .clr_i    (w_clr),
        .inc_i    (w_out_acc),
        .limit_i  (r_exp),
        .cnt_o    (out_cnt_o),
        .hit_o    (w_out_hit)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state     <= IDLE;
            r_cmd_start <= 1'b0;
            r_len       <= '0;
            r_exp       <= '0;
        end else if (cfg_abort_i) begin
            r_state     <= IDLE;
            r_cmd_start <= 1'b1;
        end else begin
            r_cmd_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_clr) begin
                        r_len       <= cfg_len_i;
                        r_exp       <= (!cfg_bypass_i && is_acc_mode(cfg_mode_i))
                                       ? LEN_WIDTH'(1) : cfg_len_i;
                        r_state     <= START;
                        r_cmd_start <= 1'b1;
                    end else if (w_launch) begin
                        r_state <= DONE;
                    end
                end
                START: r_state <= RUN;
                RUN: begin
                    if (w_in_hit && w_out_hit) begin
                        r_state <= DONE;
                    end else if (w_in_hit) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_in_hit && w_out_hit) begin
                        r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udma_filter_au_sched.sv
// Directed bench for udma_filter_au_sched: the bench plays source, AU and sink,
// records handshake events per job and compares them with hand-computed values.
module tb_udma_filter_au_sched;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          resetn_i;
    logic          cfg_start_i, cfg_abort_i, cfg_bypass_i;
    logic [3:0]    cfg_mode_i;
    logic [LW-1:0] cfg_len_i;
    logic          au_cmd_start_o;
    logic          src_valid_i, src_ready_o;
    logic          au_opa_valid_o, au_opa_ready_i, au_opa_sof_o, au_opa_eof_o;
    logic          au_out_valid_i, au_out_ready_o;
    logic          sink_valid_o, sink_ready_i;
    logic          busy_o, done_o;
    logic [LW-1:0] in_cnt_o, out_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int n_cmd, n_done, n_busy, n_acc, n_sof, n_eof, sof_idx, eof_idx, eof_cyc;
    int sink_cyc, n_sink, n_pop, n_rdy_err, pend, out_at_done, done_cyc, start_cyc;
    bit acc_mode, tog;

    always #5 clk = ~clk;

    udma_filter_au_sched #(.LEN_WIDTH(LW)) dut (
        .clk_i          (clk),
        .resetn_i       (resetn_i),
        .cfg_start_i    (cfg_start_i),
        .cfg_abort_i    (cfg_abort_i),
        .cfg_mode_i     (cfg_mode_i),
        .cfg_bypass_i   (cfg_bypass_i),
        .cfg_len_i      (cfg_len_i),
        .au_cmd_start_o (au_cmd_start_o),
        .src_valid_i    (src_valid_i),
        .src_ready_o    (src_ready_o),
        .au_opa_valid_o (au_opa_valid_o),
        .au_opa_ready_i (au_opa_ready_i),
        .au_opa_sof_o   (au_opa_sof_o),
        .au_opa_eof_o   (au_opa_eof_o),
        .au_out_valid_i (au_out_valid_i),
        .au_out_ready_o (au_out_ready_o),
        .sink_valid_o   (sink_valid_o),
        .sink_ready_i   (sink_ready_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .in_cnt_o       (in_cnt_o),
        .out_cnt_o      (out_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_mon();
        n_cmd = 0; n_done = 0; n_busy = 0; n_acc = 0; n_sof = 0; n_eof = 0;
        sof_idx = -1; eof_idx = -1; eof_cyc = 0; sink_cyc = 0; n_sink = 0; n_pop = 0;
        n_rdy_err = 0; pend = 0; out_at_done = -1; done_cyc = 0; start_cyc = 0;
        au_out_valid_i = 1'b0;
    endtask

    // One clock: observe at negedge, then update the AU model and sink just after posedge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (au_cmd_start_o) n_cmd++;
        if (busy_o) n_busy++;
        if (done_o) begin
            n_done++;
            done_cyc    = cyc;
            out_at_done = int'(out_cnt_o);
        end
        if (au_opa_valid_o && au_opa_ready_i) begin
            if (au_opa_sof_o) begin n_sof++; sof_idx = n_acc; end
            if (au_opa_eof_o) begin n_eof++; eof_idx = n_acc; eof_cyc = cyc; end
            if (!acc_mode || au_opa_eof_o) pend++;
            n_acc++;
        end
        if (au_out_valid_i && au_out_ready_o) begin
            pend--;
            n_pop++;
        end
        if (sink_valid_o && sink_ready_i) begin
            n_sink++;
            sink_cyc = cyc;
        end
        if (busy_o && !au_cmd_start_o && (au_out_ready_o != sink_ready_i)) n_rdy_err++;
        @(posedge clk);
        #1;
        if (tog) sink_ready_i = !sink_ready_i;
        au_out_valid_i = (pend > 0);
    endtask

    task automatic run_job(input int mode, input int len, input bit toggle, input bit restart);
        bit restarted = 1'b0;
        reset_mon();
        acc_mode     = (mode == 2);
        tog          = toggle;
        sink_ready_i = 1'b1;
        src_valid_i  = 1'b1;
        cfg_mode_i   = 4'(mode);
        cfg_len_i    = LW'(len);
        cfg_start_i  = 1'b1;
        tick();
        start_cyc   = cyc;
        cfg_start_i = 1'b0;
        for (int i = 0; i < 200 && n_done == 0; i++) begin
            tick();
            if (restart && !restarted && n_acc == 2) begin
                cfg_start_i = 1'b1;
                cfg_len_i   = LW'(9);
                restarted   = 1'b1;
            end else begin
                cfg_start_i = 1'b0;
            end
        end
        cfg_start_i = 1'b0;
        check_eq("job_done_within_budget", 32'(n_done != 0), 1);
        repeat (8) tick();
        tog          = 1'b0;
        sink_ready_i = 1'b1;
    endtask

    initial begin
        resetn_i       = 1'b0;
        cfg_start_i    = 1'b0;
        cfg_abort_i    = 1'b0;
        cfg_bypass_i   = 1'b0;
        cfg_mode_i     = 4'd0;
        cfg_len_i      = '0;
        src_valid_i    = 1'b0;
        au_opa_ready_i = 1'b1;
        sink_ready_i   = 1'b0;
        tog            = 1'b0;
        acc_mode       = 1'b0;
        reset_mon();
        repeat (2) tick();
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_cmd_start", 32'(au_cmd_start_o), 0);
        check_eq("rst_in_cnt", 32'(in_cnt_o), 0);
        check_eq("rst_out_cnt", 32'(out_cnt_o), 0);
        check_eq("rst_src_ready", 32'(src_ready_o), 0);
        resetn_i = 1'b1;
        repeat (2) tick();

        // Plain per-sample mode, everything ready.
        run_job(0, 4, 1'b0, 1'b0);
        check_eq("t1_cmd_start_pulses", 32'(n_cmd), 1);
        check_eq("t1_sof_count", 32'(n_sof), 1);
        check_eq("t1_sof_idx", 32'(sof_idx), 0);
        check_eq("t1_eof_count", 32'(n_eof), 1);
        check_eq("t1_eof_idx", 32'(eof_idx), 3);
        check_eq("t1_results", 32'(n_sink), 4);
        check_eq("t1_done_pulses", 32'(n_done), 1);
        check_eq("t1_in_cnt", 32'(in_cnt_o), 4);
        check_eq("t1_out_cnt", 32'(out_cnt_o), 4);

        // Accumulate mode: one result per frame.
        run_job(2, 8, 1'b0, 1'b0);
        check_eq("t2_results", 32'(n_sink), 1);
        check_eq("t2_result_after_eof", 32'(sink_cyc > eof_cyc), 1);
        check_eq("t2_out_cnt_at_done", 32'(out_at_done), 1);
        check_eq("t2_in_cnt", 32'(in_cnt_o), 8);
        check_eq("t2_done_pulses", 32'(n_done), 1);
        check_eq("t2_busy_after", 32'(busy_o), 0);

        // Sink backpressure toggling 1010.
        run_job(0, 5, 1'b1, 1'b0);
        check_eq("t3_ready_mirror_errs", 32'(n_rdy_err), 0);
        check_eq("t3_results", 32'(n_sink), 5);
        check_eq("t3_au_pops", 32'(n_pop), 5);
        check_eq("t3_out_cnt", 32'(out_cnt_o), 5);

        // Zero-length job.
        run_job(0, 0, 1'b0, 1'b0);
        check_eq("t4_done_pulses", 32'(n_done), 1);
        check_eq("t4_done_latency_ok", 32'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 1);
        check_eq("t4_cmd_start_pulses", 32'(n_cmd), 0);
        check_eq("t4_busy_cycles", 32'(n_busy), 0);

        // Abort after three of ten samples.
        reset_mon();
        acc_mode    = 1'b0;
        src_valid_i = 1'b1;
        cfg_mode_i  = 4'd0;
        cfg_len_i   = LW'(10);
        cfg_start_i = 1'b1;
        tick();
        cfg_start_i = 1'b0;
        for (int i = 0; i < 50 && n_acc < 3; i++) tick();
        src_valid_i = 1'b0;
        cfg_abort_i = 1'b1;
        n_cmd       = 0;
        tick();
        cfg_abort_i = 1'b0;
        repeat (4) tick();
        check_eq("t5_abort_cmd_start", 32'(n_cmd), 1);
        check_eq("t5_no_done", 32'(n_done), 0);
        check_eq("t5_in_cnt", 32'(in_cnt_o), 3);
        check_eq("t5_accepted", 32'(n_acc), 3);
        check_eq("t5_busy_after", 32'(busy_o), 0);
        run_job(0, 2, 1'b0, 1'b0);
        check_eq("t5_next_done", 32'(n_done), 1);
        check_eq("t5_next_results", 32'(n_sink), 2);
        check_eq("t5_next_in_cnt", 32'(in_cnt_o), 2);

        // Second start during RUN must be ignored.
        run_job(0, 4, 1'b0, 1'b1);
        check_eq("t6_done_pulses", 32'(n_done), 1);
        check_eq("t6_accepted", 32'(n_acc), 4);
        check_eq("t6_in_cnt", 32'(in_cnt_o), 4);
        check_eq("t6_cmd_start_pulses", 32'(n_cmd), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
